// File: rtl/uart_transmitter.sv
// UART transmitter: idle-high line, 1 start bit, DATA_BITS data bits LSB-first, optional even parity, 1 stop bit.
// Define UART_TX_PARITY_EN to insert the even-parity bit between the data bits and the stop bit.
module uart_transmitter #(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 valid_in,
  output logic                 ready_out,
  output logic                 tx,
  output logic                 busy
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]     cyc_cnt_q, cyc_cnt_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 bit_done;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  assign ready_out = (state_q == S_IDLE);
  assign tx        = tx_q;
  assign busy      = busy_q;
  assign bit_done  = (cyc_cnt_q == CNT_LAST);

  // State, counters and line register; reset abandons any partial frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      cyc_cnt_q <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      cyc_cnt_q <= cyc_cnt_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  // Next state; tx_d depends on the current state only, so the line lags the state by one clock.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    cyc_cnt_d = cyc_cnt_q;
    tx_d      = 1'b1;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif

    if (state_q != S_IDLE) begin
      cyc_cnt_d = bit_done ? '0 : cyc_cnt_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (valid_in) begin
          shift_d   = data_in;
          bit_cnt_d = '0;
          cyc_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
          parity_d  = ^data_in;
`endif
          state_d   = S_START;
        end
      end
      S_START: begin
        tx_d = 1'b0;
        if (bit_done) state_d = S_DATA;
      end
      S_DATA: begin
        tx_d = shift_q[0];
        if (bit_done) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d   = S_PARITY;
`else
            state_d   = S_STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        tx_d = parity_q;
        if (bit_done) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        tx_d = 1'b1;
        if (bit_done) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter at CLKS_PER_BIT=4, DATA_BITS=8.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_uart_transmitter;

  localparam int unsigned DB  = 8;
  localparam int unsigned CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned NBITS = 11;
`else
  localparam int unsigned NBITS = 10;
`endif
  localparam int unsigned FRAME = NBITS * CPB;

  logic          clk;
  logic          rst;
  logic [DB-1:0] data_in;
  logic          valid_in;
  logic          ready_out;
  logic          tx;
  logic          busy;

  int checks = 0;
  int errors = 0;

  uart_transmitter #(.DATA_BITS(DB), .CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .valid_in (valid_in),
    .ready_out(ready_out),
    .tx       (tx),
    .busy     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected line level at sample j after the handshake edge (j=0 is still idle).
  function automatic logic exp_tx(input logic [7:0] d, input int j);
    int k;
    if (j == 0) return 1'b1;
    k = (j - 1) / CPB;
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
`ifdef UART_TX_PARITY_EN
    if (k == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  // Handshake a word: called on a falling edge with the block idle; returns at sample j=0.
  task automatic start_send(input logic [7:0] d, input string name);
    checks++;
    if (ready_out !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_before_send got %b exp 1", name, ready_out);
    end
    data_in  = d;
    valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  // Walk one whole frame from sample j=0 to j=FRAME; data_in becomes mid_d at j=10.
  task automatic check_frame(input logic [7:0] d, input logic [7:0] mid_d, input string name);
    logic exp_rdy;
    for (int j = 0; j <= int'(FRAME); j++) begin
      if (j > 0) @(negedge clk);
      if (j == 10) data_in = mid_d;
      exp_rdy = (j == int'(FRAME));
      checks++;
      if (tx !== exp_tx(d, j)) begin
        errors++;
        $display("FAIL %s tx j=%0d got %b exp %b", name, j, tx, exp_tx(d, j));
      end
      checks++;
      if (ready_out !== exp_rdy) begin
        errors++;
        $display("FAIL %s ready j=%0d got %b exp %b", name, j, ready_out, exp_rdy);
      end
      checks++;
      if (busy !== !exp_rdy) begin
        errors++;
        $display("FAIL %s busy j=%0d got %b exp %b", name, j, busy, !exp_rdy);
      end
    end
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    valid_in = 1'b0;
    data_in  = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({tx, ready_out, busy} !== 3'b110) begin
      errors++;
      $display("FAIL reset_held tx/ready/busy got %b exp 110", {tx, ready_out, busy});
    end
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      checks++;
      if ({tx, ready_out, busy} !== 3'b110) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d tx/ready/busy got %b exp 110", i, {tx, ready_out, busy});
      end
    end
  endtask

  task automatic test_single_a5();
    start_send(8'hA5, "a5");
    check_frame(8'hA5, 8'hA5, "a5");
  endtask

  // valid_in held high: 8'h00 accepted, 8'hFF waits until the block is idle again.
  task automatic test_back_to_back();
    checks++;
    if (ready_out !== 1'b1) begin
      errors++;
      $display("FAIL b2b ready_before_send got %b exp 1", ready_out);
    end
    data_in  = 8'h00;
    valid_in = 1'b1;
    @(negedge clk);
    data_in = 8'hFF;
    check_frame(8'h00, 8'hFF, "b2b_first");
    @(negedge clk);
    valid_in = 1'b0;
    check_frame(8'hFF, 8'hFF, "b2b_second");
  endtask

  task automatic test_mid_change();
    start_send(8'h3C, "mid_change");
    check_frame(8'h3C, 8'hC3, "mid_change");
  endtask

  task automatic test_reset_mid_frame();
    start_send(8'h55, "rst_mid");
    repeat (18) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (tx !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid tx got %b exp 1", tx);
    end
    checks++;
    if (ready_out !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid ready got %b exp 1", ready_out);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid busy got %b exp 0", busy);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    start_send(8'h0F, "after_rst");
    check_frame(8'h0F, 8'h0F, "after_rst");
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    start_send(8'h07, "parity_07");
    check_frame(8'h07, 8'h07, "parity_07");
    start_send(8'h03, "parity_03");
    check_frame(8'h03, 8'h03, "parity_03");
  endtask
`endif

  initial begin
    test_reset();
    test_single_a5();
    test_back_to_back();
    test_mid_change();
    test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
